m68k_bus_ctrl: RTL and testbench

- Parametrised 68000 bus controller between fx68k and N memory/peripheral regions.
- Replaces ad-hoc chip-select decode and always-asserted DTACK.
- Per region: address decode on A[23:18], programmable wait states, external ready, byte-lane write strobes, registered read-data capture.
- Generates DTACK/VPA/BERR, including a bus-error timeout for unmapped accesses; runs on the CPU clock.

---
 rtl/m68k_bus_pkg.sv | 16 +
 rtl/m68k_region_match.sv | 21 ++
 rtl/m68k_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_m68k_bus_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and helpers for the 68000 bus controller.
package m68k_bus_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, HOLD, PERIPH, ERR} state_t;

  localparam int DEC_W = 6;
  localparam logic [2:0] FC_IACK = 3'b111;

  // Pull field i of width w (w <= 16) out of a packed per-region vector.
  function automatic logic [15:0] get_field(input logic [127:0] vec, input int w, input int i);
    logic [127:0] s;
    logic [15:0]  r;
    s = vec >> (i * w);
    for (int b = 0; b < 16; b++) r[b] = (b < w) ? s[b] : 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/m68k_region_match.sv
// A[23:18] region comparator with lowest-index priority.
module m68k_region_match import m68k_bus_pkg::*; #(
  parameter int NREG = 4,
  parameter int IW   = 2,
  parameter logic [NREG*DEC_W-1:0] REGION_BASE = '0
) (
  input  logic [DEC_W-1:0] dec,
  output logic             hit,
  output logic [IW-1:0]    idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (dec == REGION_BASE[k*DEC_W +: DEC_W]) begin
        hit = 1'b1;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/m68k_bus_ctrl.sv
// fx68k bus controller: region decode, wait states, DTACK/VPA/BERR generation.
// Optional macro M68K_BUS_IACK_EN routes FC=7 cycles to the autovector (VPA) path.
module m68k_bus_ctrl import m68k_bus_pkg::*; #(
  parameter int NREG = 4,
  parameter logic [NREG*DEC_W-1:0] REGION_BASE = {6'h20, 6'h18, 6'h04, 6'h00},
  parameter logic [NREG*4-1:0]     REGION_WAIT = {4'd1, 4'd0, 4'd1, 4'd1},
  parameter logic [DEC_W-1:0]      VPA_BASE    = 6'h18,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [22:0]        cpu_a,
  input  logic               cpu_as_n,
  input  logic               cpu_uds_n,
  input  logic               cpu_lds_n,
  input  logic               cpu_rw,
  input  logic [2:0]         cpu_fc,
  output logic [15:0]        cpu_din,
  output logic               dtack_n,
  output logic               vpa_n,
  output logic               berr_n,
  output logic [NREG-1:0]    region_cs,
  output logic [NREG-1:0]    region_we,
  output logic [1:0]         region_be,
  input  logic [NREG-1:0]    region_rdy,
  input  logic [NREG*16-1:0] region_rdata
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t state, state_d;
  logic [3:0]      wcnt, wcnt_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [IW-1:0]   idx, idx_d, hit_idx;
  logic            hit, vpa_hit, periph, start, as_q;
  logic [NREG-1:0] cs_d, we_d;
  logic [1:0]      be_d;
  logic [15:0]     din_d, wfield, rfield;
  logic            dtack_d, vpa_d, berr_d;
  logic [DEC_W-1:0] dec;

  assign dec = cpu_a[22:17];

  m68k_region_match #(.NREG(NREG), .IW(IW), .REGION_BASE(REGION_BASE)) u_match (
    .dec(dec), .hit(hit), .idx(hit_idx)
  );

  assign vpa_hit = (dec == VPA_BASE);
`ifdef M68K_BUS_IACK_EN
  assign periph = vpa_hit || (cpu_fc == FC_IACK);
  logic unused;
  assign unused = ^cpu_a[16:0];
`else
  assign periph = vpa_hit;
  logic unused;
  assign unused = ^{cpu_a[16:0], cpu_fc};
`endif

  // as_q gates starts so a new access needs one sampled AS-high edge first.
  assign start  = !cpu_as_n && (!cpu_uds_n || !cpu_lds_n) && as_q;
  assign wfield = get_field(128'(REGION_WAIT), 4, int'(hit_idx));
  assign rfield = get_field(128'(region_rdata), 16, int'(idx));

  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    tcnt_d  = tcnt;
    idx_d   = idx;
    cs_d    = region_cs;
    we_d    = '0;
    be_d    = region_be;
    din_d   = cpu_din;
    dtack_d = dtack_n;
    vpa_d   = vpa_n;
    berr_d  = berr_n;
    if (state != IDLE && cpu_as_n) begin
      // AS high ends any access: abort mid-flight or normal release from HOLD.
      state_d = IDLE;
      cs_d    = '0;
      be_d    = '0;
      dtack_d = 1'b1;
      vpa_d   = 1'b1;
      berr_d  = 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx_d  = hit_idx;
          be_d   = {~cpu_uds_n, ~cpu_lds_n};
          tcnt_d = '0;
          if (periph) state_d = PERIPH;
          else if (hit) begin
            cs_d          = '0;
            cs_d[hit_idx] = 1'b1;
            wcnt_d        = wfield[3:0];
            state_d       = WAIT;
          end else state_d = ERR;
        end
        WAIT: begin
          if (wcnt == '0 && region_rdy[idx]) begin
            dtack_d = 1'b0;
            if (cpu_rw) din_d = rfield;
            else        we_d[idx] = 1'b1;
            state_d = HOLD;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            berr_d  = 1'b0;
            state_d = HOLD;
          end else begin
            if (wcnt != '0) wcnt_d = wcnt - 1'b1;
            tcnt_d = tcnt + 1'b1;
          end
        end
        PERIPH: begin
          vpa_d   = 1'b0;
          state_d = HOLD;
        end
        ERR: begin
          if (tcnt == TW'(TIMEOUT - 1)) begin
            berr_d  = 1'b0;
            state_d = HOLD;
          end else tcnt_d = tcnt + 1'b1;
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      tcnt      <= '0;
      idx       <= '0;
      as_q      <= 1'b0;
      region_cs <= '0;
      region_we <= '0;
      region_be <= '0;
      cpu_din   <= '0;
      dtack_n   <= 1'b1;
      vpa_n     <= 1'b1;
      berr_n    <= 1'b1;
    end else begin
      state     <= state_d;
      wcnt      <= wcnt_d;
      tcnt      <= tcnt_d;
      idx       <= idx_d;
      as_q      <= cpu_as_n;
      region_cs <= cs_d;
      region_we <= we_d;
      region_be <= be_d;
      cpu_din   <= din_d;
      dtack_n   <= dtack_d;
      vpa_n     <= vpa_d;
      berr_n    <= berr_d;
    end
  end
endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Scoreboard bench for m68k_bus_ctrl: stimulus pushes expected acks, monitor checks them.
module tb_m68k_bus_ctrl;
  logic        clk = 0, reset_n = 1;
  logic [22:0] cpu_a = '0;
  logic        cpu_as_n = 1, cpu_uds_n = 1, cpu_lds_n = 1, cpu_rw = 1;
  logic [2:0]  cpu_fc = 3'd5;
  logic [15:0] cpu_din;
  logic        dtack_n, vpa_n, berr_n;
  logic [3:0]  region_cs, region_we;
  logic [3:0]  region_rdy = 4'b1111;
  logic [1:0]  region_be;
  logic [63:0] region_rdata = {16'hC0DE, 16'h2222, 16'h1111, 16'hBEEF};

  m68k_bus_ctrl #(
    .NREG(4), .REGION_BASE({6'h20, 6'h18, 6'h04, 6'h00}),
    .REGION_WAIT({4'd5, 4'd0, 4'd1, 4'd1}), .VPA_BASE(6'h18), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_as_n(cpu_as_n),
    .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw), .cpu_fc(cpu_fc),
    .cpu_din(cpu_din), .dtack_n(dtack_n), .vpa_n(vpa_n), .berr_n(berr_n),
    .region_cs(region_cs), .region_we(region_we), .region_be(region_be),
    .region_rdy(region_rdy), .region_rdata(region_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;  // {berr, vpa, dtack} active
    logic [15:0] din;
    logic [3:0]  we;
    logic [3:0]  cs;
    logic [1:0]  be;
    int          lat;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e;
  int checks = 0, failures = 0, cyc = 0, start_cyc = 0, ack_count = 0, we_count = 0;
  bit ack_prev = 0, chk_we_off = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [2:0] k, input logic [15:0] d, input logic [3:0] w,
                              input logic [3:0] c, input logic [1:0] b, input int l);
    rsp_t r;
    r.kind = k; r.din = d; r.we = w; r.cs = c; r.be = b; r.lat = l;
    return r;
  endfunction

  // Monitor: first cycle of any acknowledge pops and checks one expectation.
  always @(negedge clk) begin
    if (!reset_n) begin
      ack_prev   = 0;
      chk_we_off = 0;
    end else begin
      if (chk_we_off) begin
        chk("we_one_cycle", 32'(region_we), 32'h0);
        chk_we_off = 0;
      end
      if (region_we != 4'b0) we_count++;
      if ((!dtack_n || !vpa_n || !berr_n) && !ack_prev) begin
        ack_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack kind=%b", {~berr_n, ~vpa_n, ~dtack_n});
        end else begin
          e = exp_q.pop_front();
          chk("kind", 32'({~berr_n, ~vpa_n, ~dtack_n}), 32'(e.kind));
          chk("din",  32'(cpu_din),   32'(e.din));
          chk("we",   32'(region_we), 32'(e.we));
          chk("cs",   32'(region_cs), 32'(e.cs));
          chk("be",   32'(region_be), 32'(e.be));
          chk("lat",  32'(cyc - start_cyc), 32'(e.lat));
        end
        if (!dtack_n && region_we != 4'b0) chk_we_off = 1;
      end
      ack_prev = !dtack_n || !vpa_n || !berr_n;
    end
  end

  task automatic start_acc(input logic [23:0] addr, input logic rw, input logic uds,
                           input logic lds, input logic [2:0] fc);
    @(negedge clk);
    cpu_a = addr[23:1]; cpu_rw = rw; cpu_fc = fc;
    cpu_uds_n = uds; cpu_lds_n = lds; cpu_as_n = 0;
    @(posedge clk);
    #1 start_cyc = cyc;
  endtask

  task automatic wait_ack();
    int n0 = ack_count;
    int k = 0;
    while (ack_count == n0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (ack_count == n0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout waited=%0d cycles", k);
    end
  endtask

  task automatic end_acc();
    @(negedge clk);
    chk("hold_ack", 32'(!dtack_n || !vpa_n || !berr_n), 32'h1);
    cpu_as_n = 1; cpu_uds_n = 1; cpu_lds_n = 1;
    @(negedge clk);
    chk("release_acks", 32'({dtack_n, vpa_n, berr_n}), 32'h7);
    chk("release_cs", 32'(region_cs), 32'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_acks"}, 32'({dtack_n, vpa_n, berr_n}), 32'h7);
    chk({tag, "_cs"},   32'(region_cs), 32'h0);
    chk({tag, "_we"},   32'(region_we), 32'h0);
    chk({tag, "_be"},   32'(region_be), 32'h0);
    chk({tag, "_din"},  32'(cpu_din),   32'h0);
  endtask

  initial begin
    int n0, w0;
    #2 reset_n = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1;
    repeat (2) @(negedge clk);

    // Region 0 read, wait 1
    exp_q.push_back(mk(3'b001, 16'hBEEF, 4'b0000, 4'b0001, 2'b11, 2));
    start_acc(24'h000100, 1, 0, 0, 3'd5); wait_ack(); end_acc();

    // Region 1 write, lower byte only
    exp_q.push_back(mk(3'b001, 16'hBEEF, 4'b0010, 4'b0010, 2'b01, 2));
    start_acc(24'h100002, 0, 1, 0, 3'd5); wait_ack(); end_acc();

    // Region 3 read, ready low for 10 cycles
    region_rdy[3] = 0;
    exp_q.push_back(mk(3'b001, 16'hC0DE, 4'b0000, 4'b1000, 2'b11, 11));
    start_acc(24'h800000, 1, 0, 0, 3'd5);
    while (cyc < start_cyc + 10) @(negedge clk);
    region_rdy[3] = 1;
    wait_ack(); end_acc();

    // Region 3 write, ready never rises: bus error, no write pulse
    region_rdy[3] = 0;
    w0 = we_count;
    exp_q.push_back(mk(3'b100, 16'hC0DE, 4'b0000, 4'b1000, 2'b11, 64));
    start_acc(24'h800000, 0, 0, 0, 3'd5); wait_ack(); end_acc();
    chk("berr_no_we", 32'(we_count), 32'(w0));
    region_rdy[3] = 1;

    // VPA peripheral
    exp_q.push_back(mk(3'b010, 16'hC0DE, 4'b0000, 4'b0000, 2'b11, 1));
    start_acc(24'h600000, 1, 0, 0, 3'd5); wait_ack(); end_acc();

    // Unmapped
    exp_q.push_back(mk(3'b100, 16'hC0DE, 4'b0000, 4'b0000, 2'b11, 64));
    start_acc(24'h400000, 1, 0, 0, 3'd5); wait_ack(); end_acc();

    // Abort a wait-5 write when AS rises after cycle 3
    n0 = ack_count; w0 = we_count;
    start_acc(24'h800000, 0, 0, 0, 3'd5);
    while (cyc < start_cyc + 3) @(negedge clk);
    cpu_as_n = 1; cpu_uds_n = 1; cpu_lds_n = 1;
    @(negedge clk);
    chk("abort_cs", 32'(region_cs), 32'h0);
    chk("abort_be", 32'(region_be), 32'h0);
    repeat (8) @(negedge clk);
    chk("abort_no_ack", 32'(ack_count), 32'(n0));
    chk("abort_no_we", 32'(we_count), 32'(w0));

    // Interrupt acknowledge
`ifdef M68K_BUS_IACK_EN
    exp_q.push_back(mk(3'b010, 16'hC0DE, 4'b0000, 4'b0000, 2'b11, 1));
`else
    exp_q.push_back(mk(3'b100, 16'hC0DE, 4'b0000, 4'b0000, 2'b11, 64));
`endif
    start_acc(24'hFFFFF2, 1, 0, 0, 3'b111); wait_ack(); end_acc();

    // Asynchronous reset in the middle of a wait
    region_rdy[3] = 0;
    start_acc(24'h800000, 0, 0, 0, 3'd5);
    while (cyc < start_cyc + 3) @(negedge clk);
    #2 chk("pre_reset_cs", 32'(region_cs), 32'h8);
    reset_n = 0;
    #1 chk_reset_vals("async_reset");
    cpu_as_n = 1; cpu_uds_n = 1; cpu_lds_n = 1;
    region_rdy[3] = 1;
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    chk("we_total", 32'(we_count), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule
